build_phrase: RTL and testbench

//  Packs a stream of 16-bit pixel words into 128-bit phrases for the DRAM write path.
//  It is the inverse of the phrase-to-word digester.

---
 rtl/build_phrase.sv | 125 ++++++++++++
 tb/tb_build_phrase.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/build_phrase.sv
// Packs 16-bit pixel words into 128-bit DRAM phrases, lane 0 in the LSBs.
// BUILD_PHRASE_FLUSH_EN: pad and emit a partial phrase when a newframe word arrives mid-phrase.
module build_phrase #(
    parameter int WORD_WIDTH       = 16,
    parameter int WORDS_PER_PHRASE = 8
) (
    input  logic                                 clk_in,
    input  logic                                 rst_n_in,
    input  logic                                 valid_word,
    output logic                                 ready_word,
    input  logic [WORD_WIDTH-1:0]                word,
    input  logic                                 newframe_in,
    output logic                                 valid_phrase,
    input  logic                                 ready_phrase,
    output logic [WORD_WIDTH*WORDS_PER_PHRASE-1:0] phrase_data,
    output logic                                 phrase_tuser,
    output logic                                 misalign_out
);

    localparam int PW = WORD_WIDTH * WORDS_PER_PHRASE;
    localparam int AW = PW - WORD_WIDTH;
    localparam int CW = $clog2(WORDS_PER_PHRASE);
    localparam logic [CW-1:0] LAST = CW'(WORDS_PER_PHRASE - 1);

    logic [AW-1:0] acc_data_q, acc_data_d;
    logic [CW-1:0] acc_count_q, acc_count_d;
    logic          acc_tuser_q, acc_tuser_d;
    logic          out_valid_q, out_valid_d;
    logic [PW-1:0] out_data_q, out_data_d;
    logic          out_tuser_q, out_tuser_d;
    logic          misalign_q, misalign_d;
    logic          mis_seen_q, mis_seen_d;

    logic slot_free;
    logic misalign;
    logic flush_pending;
    logic flush_fire;
    logic accept;

    always_comb begin
        slot_free = !out_valid_q | ready_phrase;
        misalign  = valid_word & newframe_in & (acc_count_q != '0);
`ifdef BUILD_PHRASE_FLUSH_EN
        flush_pending = misalign;
`else
        flush_pending = 1'b0;
`endif
        flush_fire = flush_pending & slot_free;
        ready_word = rst_n_in & !((acc_count_q == LAST) & !slot_free) & !flush_pending;
        accept     = valid_word & ready_word;

        acc_data_d  = acc_data_q;
        acc_count_d = acc_count_q;
        acc_tuser_d = acc_tuser_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_tuser_d = out_tuser_q;

        if (out_valid_q & ready_phrase)
            out_valid_d = 1'b0;

        if (accept) begin
            if (misalign) begin
                // Drop the partial phrase; the newframe word restarts at lane 0
                acc_data_d  = AW'(word);
                acc_count_d = CW'(1);
                acc_tuser_d = 1'b1;
            end else if (acc_count_q == LAST) begin
                out_valid_d = 1'b1;
                out_data_d  = {word, acc_data_q};
                out_tuser_d = acc_tuser_q;
                acc_data_d  = '0;
                acc_count_d = '0;
            end else begin
                for (int k = 0; k < WORDS_PER_PHRASE - 1; k++)
                    if (acc_count_q == CW'(k))
                        acc_data_d[k*WORD_WIDTH +: WORD_WIDTH] = word;
                acc_count_d = acc_count_q + CW'(1);
                if (acc_count_q == '0)
                    acc_tuser_d = newframe_in;
            end
        end

        // Unwritten lanes are already zero, so the partial image is the padded phrase
        if (flush_fire) begin
            out_valid_d = 1'b1;
            out_data_d  = PW'(acc_data_q);
            out_tuser_d = acc_tuser_q;
            acc_data_d  = '0;
            acc_count_d = '0;
            acc_tuser_d = 1'b0;
        end

        misalign_d = misalign & !mis_seen_q;
        mis_seen_d = misalign & !accept & !flush_fire;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            acc_data_q  <= '0;
            acc_count_q <= '0;
            acc_tuser_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tuser_q <= 1'b0;
            misalign_q  <= 1'b0;
            mis_seen_q  <= 1'b0;
        end else begin
            acc_data_q  <= acc_data_d;
            acc_count_q <= acc_count_d;
            acc_tuser_q <= acc_tuser_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tuser_q <= out_tuser_d;
            misalign_q  <= misalign_d;
            mis_seen_q  <= mis_seen_d;
        end
    end

    assign valid_phrase = out_valid_q;
    assign phrase_data  = out_data_q;
    assign phrase_tuser = out_tuser_q;
    assign misalign_out = misalign_q;

endmodule

// File: tb/tb_build_phrase.sv
// Scoreboard bench for build_phrase; expectations follow BUILD_PHRASE_FLUSH_EN if defined.
module tb_build_phrase;

    logic         clk_in = 1'b0;
    logic         rst_n_in = 1'b0;
    logic         valid_word = 1'b0;
    logic         ready_word;
    logic [15:0]  word = '0;
    logic         newframe_in = 1'b0;
    logic         valid_phrase;
    logic         ready_phrase = 1'b0;
    logic [127:0] phrase_data;
    logic         phrase_tuser;
    logic         misalign_out;

    int tests = 0;
    int fails = 0;
    int mis_cnt = 0;
    logic [128:0] exp_q[$];

    build_phrase dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .valid_word   (valid_word),
        .ready_word   (ready_word),
        .word         (word),
        .newframe_in  (newframe_in),
        .valid_phrase (valid_phrase),
        .ready_phrase (ready_phrase),
        .phrase_data  (phrase_data),
        .phrase_tuser (phrase_tuser),
        .misalign_out (misalign_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [128:0] act,
                         input logic [128:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Inputs only change at posedge+1, so negedge values hold at the next edge
    always @(negedge clk_in) begin
        if (misalign_out)
            mis_cnt++;
        if (rst_n_in && valid_phrase && ready_phrase) begin
            if (exp_q.size() == 0) begin
                check("unexpected_phrase", {phrase_tuser, phrase_data}, '1);
            end else begin
                check("phrase", {phrase_tuser, phrase_data}, exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [15:0] w, input logic nf, output int waits);
        logic rdy;
        waits = 0;
        valid_word  = 1'b1;
        word        = w;
        newframe_in = nf;
        forever begin
            @(negedge clk_in);
            rdy = ready_word;
            @(posedge clk_in);
            #1;
            if (rdy)
                break;
            waits++;
            if (waits > 200) begin
                check("send_timeout", 129'(waits), 129'(0));
                break;
            end
        end
        valid_word  = 1'b0;
        newframe_in = 1'b0;
    endtask

    initial begin
        int w;
        int stalls;

        #3;
        check("rst_ready_word", 129'(ready_word), 129'(0));
        check("rst_valid", 129'(valid_phrase), 129'(0));
        check("rst_data_tuser", {phrase_tuser, phrase_data}, 129'(0));
        check("rst_misalign", 129'(misalign_out), 129'(0));
        #9 rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;
        check("post_rst_ready", 129'(ready_word), 129'(1));

        // Basic pack, first word flagged newframe
        ready_phrase = 1'b1;
        for (int i = 1; i <= 7; i++)
            send(16'(i), i == 1, w);
        check("t1_not_yet_valid", 129'(valid_phrase), 129'(0));
        exp_q.push_back({1'b1, 128'h0008_0007_0006_0005_0004_0003_0002_0001});
        send(16'h0008, 1'b0, w);
        check("t1_latency_valid", 129'(valid_phrase), 129'(1));
        check("t1_tuser", 129'(phrase_tuser), 129'(1));

        // Streaming at full rate
        stalls = 0;
        for (int i = 0; i < 24; i++) begin
            if (i % 8 == 7)
                exp_q.push_back({1'b0, {8{16'hDEAD}}});
            send(16'hDEAD, 1'b0, w);
            stalls += w;
        end
        check("t2_no_stall", 129'(stalls), 129'(0));

        // Backpressure
        for (int i = 1; i <= 8; i++)
            send(16'h0100 + 16'(i), 1'b0, w);
        exp_q.push_back({1'b0, 128'h0108_0107_0106_0105_0104_0103_0102_0101});
        ready_phrase = 1'b0;
        stalls = 0;
        for (int i = 1; i <= 7; i++) begin
            send(16'h0200 + 16'(i), 1'b0, w);
            stalls += w;
        end
        check("t3_seven_accepted", 129'(stalls), 129'(0));
        valid_word = 1'b1;
        word       = 16'h0208;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_in);
            check("t3_stall_ready", 129'(ready_word), 129'(0));
            check("t3_hold", {valid_phrase, phrase_tuser, phrase_data},
                  {2'b10, 128'h0108_0107_0106_0105_0104_0103_0102_0101});
        end
        @(posedge clk_in);
        #1;
        ready_phrase = 1'b1;
        exp_q.push_back({1'b0, 128'h0208_0207_0206_0205_0204_0203_0202_0201});
        send(16'h0208, 1'b0, w);
        check("t3_resume_wait", 129'(w), 129'(0));
        for (int i = 9; i <= 16; i++)
            send(16'h0200 + 16'(i), 1'b0, w);
        exp_q.push_back({1'b0, 128'h0210_020F_020E_020D_020C_020B_020A_0209});
        repeat (3) @(posedge clk_in);
        #1;
        check("t3_drained", 129'(exp_q.size()), 129'(0));
        check("no_misalign_yet", 129'(mis_cnt), 129'(0));

        // Misalign: three words then a newframe word
        for (int i = 0; i < 3; i++)
            send(16'hABBA, 1'b0, w);
`ifdef BUILD_PHRASE_FLUSH_EN
        exp_q.push_back({1'b0, 128'h0000_0000_0000_0000_0000_ABBA_ABBA_ABBA});
        send(16'h3141, 1'b1, w);
        check("t4_flush_bubble", 129'(w), 129'(1));
`else
        send(16'h3141, 1'b1, w);
        check("t5_no_bubble", 129'(w), 129'(0));
`endif
        for (int i = 1; i <= 7; i++)
            send(16'(i), 1'b0, w);
        exp_q.push_back({1'b1, 128'h0007_0006_0005_0004_0003_0002_0001_3141});
        repeat (3) @(posedge clk_in);
        #1;
        check("misalign_pulses", 129'(mis_cnt), 129'(1));
        check("misalign_drained", 129'(exp_q.size()), 129'(0));

        // Async reset with a held phrase and a partial one pending
        ready_phrase = 1'b0;
        for (int i = 1; i <= 11; i++)
            send(16'h0500 + 16'(i), 1'b0, w);
        check("t6_pre_valid", 129'(valid_phrase), 129'(1));
        #2 rst_n_in = 1'b0;
        #1;
        check("t6_async_valid", 129'(valid_phrase), 129'(0));
        check("t6_async_ready", 129'(ready_word), 129'(0));
        check("t6_async_data", 129'(phrase_data), 129'(0));
        @(negedge clk_in);
        #2 rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;
        ready_phrase = 1'b1;
        for (int i = 1; i <= 8; i++)
            send(16'h0010 + 16'(i), 1'b0, w);
        exp_q.push_back({1'b0, 128'h0018_0017_0016_0015_0014_0013_0012_0011});
        check("t6_fresh_valid", 129'(valid_phrase), 129'(1));
        repeat (4) @(posedge clk_in);
        #1;
        check("final_drained", 129'(exp_q.size()), 129'(0));
        check("final_misalign", 129'(mis_cnt), 129'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
